// File: rtl/barret_pkg.sv
// Constants shared by the q = 359 Barrett reducer, the arbiter
// and the modular-multiply lanes.
package barret_pkg;

    localparam int unsigned Q     = 359;
    localparam int unsigned IN_W  = 17;
    localparam int unsigned OUT_W = 9;

    // floor(2^26 / 359); quotient estimate is short by at most one
    localparam int unsigned BAR_K = 26;
    localparam int unsigned BAR_M = 186932;

    typedef logic [IN_W-1:0]  operand_t;
    typedef logic [OUT_W-1:0] residue_t;

endpackage

// File: rtl/barret_for_359.sv
// Combinational Barrett reduction of a 17-bit operand modulo 359.
// Valid for operands below 359*359.
module barret_for_359
    import barret_pkg::*;
(
    input  operand_t din_a,
    output residue_t dout_r
);

    logic [34:0] prod;
    logic [8:0]  qhat;
    logic [17:0] qm;
    logic [9:0]  r;

    assign prod   = 35'(din_a) * 35'(BAR_M);
    assign qhat   = 9'(prod >> BAR_K);
    assign qm     = 18'(qhat) * 18'(Q);
    assign r      = 10'(18'(din_a) - qm);
    assign dout_r = (r >= 10'(Q)) ? 9'(r - 10'(Q)) : r[8:0];

endmodule

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of valid_i at or after
// ptr_i, wrapping modulo N.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    valid_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [ID_W-1:0] idx_o,
    output logic            found_o
);

    // Walk from farthest to nearest so the nearest hit wins
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid_i[(int'(ptr_i) + i) % N]) begin
                found_o = 1'b1;
                idx_o   = ID_W'((int'(ptr_i) + i) % N);
            end
        end
    end

endmodule

// File: rtl/barret_359_rr_arbiter.sv
// Round-robin arbiter sharing one mod-359 reducer between NUM_REQ
// requesters, with a single registered response stage.
module barret_359_rr_arbiter
    import barret_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [OUT_W-1:0]        rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy,
    output logic [15:0]             done_cnt
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            vld_q, vld_d;
    residue_t        dat_q, dat_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [15:0]     cnt_q, cnt_d;

    logic [ID_W-1:0] win;
    logic            found;
    logic            accept_en;
    logic            grant;
    logic            drain;
    operand_t        operand;
    residue_t        reduced;

    rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .idx_o   (win),
        .found_o (found)
    );

    assign operand = req_data[int'(win) * IN_W +: IN_W];

    barret_for_359 u_red (
        .din_a  (operand),
        .dout_r (reduced)
    );

    // rst_n gates the grant so nothing handshakes while held in reset
    assign accept_en = !vld_q || rsp_ready;
    assign grant     = accept_en && found && rst_n;
    assign drain     = vld_q && rsp_ready;
    assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;

    always_comb begin
        ptr_d = ptr_q;
        vld_d = vld_q && !rsp_ready;
        dat_d = dat_q;
        id_d  = id_q;
        cnt_d = cnt_q + 16'(drain);
        if (grant) begin
            ptr_d = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            vld_d = 1'b1;
            dat_d = reduced;
            id_d  = win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            vld_q <= 1'b0;
            dat_q <= '0;
            id_q  <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            dat_q <= dat_d;
            id_q  <= id_d;
            cnt_q <= cnt_d;
        end
    end

    assign rsp_valid = vld_q;
    assign rsp_data  = dat_q;
    assign rsp_id    = id_q;
    assign done_cnt  = cnt_q;
    assign busy      = vld_q || (|req_valid);

endmodule

// File: tb/tb_barret_359_rr_arbiter.sv
// Directed bench for the round-robin mod-359 arbiter.
module tb_barret_359_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [67:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [8:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;
    logic [15:0] done_cnt;

    int tests;
    int fails;

    barret_359_rr_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [16:0] d);
        req_data[i*17 +: 17] = d;
        req_valid[i] = 1'b1;
        tests++;
        if (d >= 17'd128881) begin
            fails++;
            $display("FAIL operand_range req%0d: operand %0d, required < 128881", i, d);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        req_data = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== 9'd0 || rsp_id !== 2'd0) begin
            fails++;
            $display("FAIL reset_rsp: valid=%0b data=%0d id=%0d, required 0/0/0", rsp_valid, rsp_data, rsp_id);
        end
        tests++;
        if (done_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_cnt: got %0d, required 0", done_cnt);
        end
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ready: got %b, required 0000", req_ready);
        end
        @(negedge clk);
        req_valid = 4'h0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        set_req(0, 17'd1000);
        rsp_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0001 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_ready: ready=%b busy=%0b, required 0001/1", req_ready, busy);
        end
        edge_sample();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 9'd282 || rsp_id !== 2'd0) begin
            fails++;
            $display("FAIL single_rsp: valid=%0b data=%0d id=%0d, required 1/282/0", rsp_valid, rsp_data, rsp_id);
        end
        @(negedge clk);
        req_valid = 4'h0;
        edge_sample();
        tests++;
        if (rsp_valid !== 1'b0 || done_cnt !== 16'd1 || rsp_data !== 9'd282 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_drain: valid=%0b cnt=%0d data=%0d busy=%0b, required 0/1/282/0", rsp_valid, done_cnt, rsp_data, busy);
        end
    endtask

    task automatic test_boundary();
        logic [16:0] ops [4];
        logic [8:0]  exp [4];
        ops = '{17'd359, 17'd128164, 17'd128880, 17'd0};
        exp = '{9'd0, 9'd1, 9'd358, 9'd0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_req(2, ops[k]);
            rsp_ready = 1'b1;
            edge_sample();
            tests++;
            if (rsp_data !== exp[k] || rsp_id !== 2'd2 || rsp_valid !== 1'b1) begin
                fails++;
                $display("FAIL boundary op=%0d: data=%0d id=%0d valid=%0b, required %0d/2/1", ops[k], rsp_data, rsp_id, rsp_valid, exp[k]);
            end
        end
        @(negedge clk);
        req_valid = 4'h0;
        edge_sample();
        tests++;
        if (done_cnt !== 16'd5) begin
            fails++;
            $display("FAIL boundary_cnt: got %0d, required 5", done_cnt);
        end
    endtask

    // Pointer sits at 3 after the boundary test
    task automatic test_round_robin();
        logic [8:0] exp [4];
        exp = '{9'd282, 9'd205, 9'd128, 9'd196};
        @(negedge clk);
        set_req(0, 17'd1000);
        set_req(1, 17'd2000);
        set_req(2, 17'd3000);
        set_req(3, 17'd128000);
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            edge_sample();
            tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'((3 + k) % 4) || rsp_data !== exp[(3 + k) % 4]) begin
                fails++;
                $display("FAIL rr_grant %0d: valid=%0b id=%0d data=%0d, required 1/%0d/%0d", k, rsp_valid, rsp_id, rsp_data, (3 + k) % 4, exp[(3 + k) % 4]);
            end
        end
        tests++;
        if (done_cnt !== 16'd12) begin
            fails++;
            $display("FAIL rr_cnt: got %0d, required 12", done_cnt);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL bp_ready: got %b, required 0000", req_ready);
        end
        for (int k = 0; k < 5; k++) begin
            edge_sample();
            tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 9'd128 || req_ready !== 4'b0000) begin
                fails++;
                $display("FAIL bp_hold %0d: valid=%0b id=%0d data=%0d ready=%b, required 1/2/128/0000", k, rsp_valid, rsp_id, rsp_data, req_ready);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b1000) begin
            fails++;
            $display("FAIL bp_release_ready: got %b, required 1000", req_ready);
        end
        edge_sample();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 9'd196 || done_cnt !== 16'd13) begin
            fails++;
            $display("FAIL bp_refill: valid=%0b id=%0d data=%0d cnt=%0d, required 1/3/196/13", rsp_valid, rsp_id, rsp_data, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if (rsp_valid !== 1'b0 || done_cnt !== 16'd0 || rsp_data !== 9'd0 || req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL rstmid_clear: valid=%0b cnt=%0d data=%0d ready=%b, required 0/0/0/0000", rsp_valid, done_cnt, rsp_data, req_ready);
        end
        req_valid = 4'b0110;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL rstmid_ready: got %b, required 0010", req_ready);
        end
        edge_sample();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 9'd205) begin
            fails++;
            $display("FAIL rstmid_grant: valid=%0b id=%0d data=%0d, required 1/1/205", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        req_valid = 4'h0;
        edge_sample();
        tests++;
        if (done_cnt !== 16'd1 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_cnt: cnt=%0d valid=%0b, required 1/0", done_cnt, rsp_valid);
        end
    endtask

    task automatic test_sweep();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v < 359; v++) begin
                @(negedge clk);
                req_valid = 4'h0;
                set_req(r, 17'(v));
                edge_sample();
                tests++;
                if (rsp_data !== 9'(v) || rsp_id !== 2'(r) || rsp_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL sweep r%0d v%0d: data=%0d id=%0d valid=%0b, required %0d/%0d/1", r, v, rsp_data, rsp_id, rsp_valid, v, r);
                end
            end
        end
        @(negedge clk);
        req_valid = 4'h0;
        edge_sample();
        tests++;
        if (done_cnt !== 16'd1436) begin
            fails++;
            $display("FAIL sweep_cnt: got %0d, required 1436", done_cnt);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_boundary();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
